// File: rtl/disp_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | disp_arbiter                                                               |
// | Round-robin owner arbitration of a 16-bit hex display among 3 requesters.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module disp_arbiter #(
  parameter int unsigned HOLD_MS  = 500,
  parameter logic [15:0] IDLE_DAT = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce1ms,
  input  logic [2:0]  req,
  input  logic [15:0] dat0,
  input  logic [15:0] dat1,
  input  logic [15:0] dat2,
  input  logic [1:0]  pt0,
  input  logic [1:0]  pt1,
  input  logic [1:0]  pt2,
  output logic [2:0]  gnt,
  output logic [15:0] disp_dat,
  output logic [1:0]  disp_sw,
  output logic        busy
);

  localparam logic [0:0]  c_ST_IDLE = 1'b0;
  localparam logic [0:0]  c_ST_OWN  = 1'b1;
  localparam logic [15:0] c_HOLD    = 16'(HOLD_MS);

  logic [0:0]  r_state;
  logic [1:0]  r_last_idx;
  logic [15:0] r_hold_cnt;

  logic [1:0]  w_idx1;
  logic [1:0]  w_idx2;
  logic [1:0]  w_idx3;
  logic [2:0]  w_last_oh;
  logic [2:0]  w_cand;
  logic        w_pick_vld;
  logic [1:0]  w_pick_idx;
  logic        w_own_req;
  logic [15:0] w_own_dat;
  logic [1:0]  w_own_pt;
  logic [15:0] w_pick_dat;
  logic [1:0]  w_pick_pt;

  function automatic logic [1:0] f_inc3(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  function automatic logic [2:0] f_onehot(input logic [1:0] i);
    case (i)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  // In OWN the current owner (always r_last_idx) is never a handover candidate.
  always_comb begin
    w_idx1    = f_inc3(r_last_idx);
    w_idx2    = f_inc3(w_idx1);
    w_idx3    = f_inc3(w_idx2);
    w_last_oh = f_onehot(r_last_idx);
    w_own_req = |(req & w_last_oh);
    w_cand    = (r_state == c_ST_OWN) ? (req & ~w_last_oh) : req;

    w_pick_vld = 1'b1;
    if (|(w_cand & f_onehot(w_idx1)))
      w_pick_idx = w_idx1;
    else if (|(w_cand & f_onehot(w_idx2)))
      w_pick_idx = w_idx2;
    else if (|(w_cand & f_onehot(w_idx3)))
      w_pick_idx = w_idx3;
    else begin
      w_pick_idx = w_idx1;
      w_pick_vld = 1'b0;
    end
  end

  always_comb begin
    case (r_last_idx)
      2'd0:    begin w_own_dat = dat0; w_own_pt = pt0; end
      2'd1:    begin w_own_dat = dat1; w_own_pt = pt1; end
      default: begin w_own_dat = dat2; w_own_pt = pt2; end
    endcase
    case (w_pick_idx)
      2'd0:    begin w_pick_dat = dat0; w_pick_pt = pt0; end
      2'd1:    begin w_pick_dat = dat1; w_pick_pt = pt1; end
      default: begin w_pick_dat = dat2; w_pick_pt = pt2; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= c_ST_IDLE;
      r_last_idx <= 2'd2;
      r_hold_cnt <= 16'd0;
      gnt        <= 3'b000;
      busy       <= 1'b0;
      disp_dat   <= IDLE_DAT;
      disp_sw    <= 2'b00;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          // Data follows the owner from the next edge on; this edge still shows idle.
          disp_dat <= IDLE_DAT;
          disp_sw  <= 2'b00;
          if (w_pick_vld) begin
            r_state    <= c_ST_OWN;
            r_last_idx <= w_pick_idx;
            r_hold_cnt <= 16'd0;
            gnt        <= f_onehot(w_pick_idx);
            busy       <= 1'b1;
          end else begin
            gnt  <= 3'b000;
            busy <= 1'b0;
          end
        end

        default: begin
          if (w_pick_vld && (!w_own_req || (r_hold_cnt == c_HOLD))) begin
            r_last_idx <= w_pick_idx;
            r_hold_cnt <= 16'd0;
            gnt        <= f_onehot(w_pick_idx);
            busy       <= 1'b1;
            disp_dat   <= w_pick_dat;
            disp_sw    <= w_pick_pt;
          end else if (!w_own_req) begin
            r_state    <= c_ST_IDLE;
            r_hold_cnt <= 16'd0;
            gnt        <= 3'b000;
            busy       <= 1'b0;
            disp_dat   <= IDLE_DAT;
            disp_sw    <= 2'b00;
          end else begin
            disp_dat <= w_own_dat;
            disp_sw  <= w_own_pt;
            if (ce1ms && (r_hold_cnt != c_HOLD))
              r_hold_cnt <= r_hold_cnt + 16'd1;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_disp_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_disp_arbiter                                                            |
// | Directed self-checking bench for disp_arbiter (HOLD_MS=3, IDLE=16'hDEAD).  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_disp_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce1ms = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [15:0] dat0 = 16'h1111;
  logic [15:0] dat1 = 16'h2222;
  logic [15:0] dat2 = 16'h3333;
  logic [1:0]  pt0 = 2'd1;
  logic [1:0]  pt1 = 2'd2;
  logic [1:0]  pt2 = 2'd3;
  logic [2:0]  gnt;
  logic [15:0] disp_dat;
  logic [1:0]  disp_sw;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  disp_arbiter #(.HOLD_MS(3), .IDLE_DAT(16'hDEAD)) dut (
    .clk(clk), .rst(rst), .ce1ms(ce1ms), .req(req),
    .dat0(dat0), .dat1(dat1), .dat2(dat2),
    .pt0(pt0), .pt1(pt1), .pt2(pt2),
    .gnt(gnt), .disp_dat(disp_dat), .disp_sw(disp_sw), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 3'b000; step();
    rst = 1'b0; step();
    n_checks++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL reset_gnt: got %b want 000", gnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (disp_dat !== 16'hDEAD) begin n_fail++; $display("FAIL reset_dat: got %h want dead", disp_dat); end
    n_checks++; if (disp_sw !== 2'b00) begin n_fail++; $display("FAIL reset_sw: got %b want 00", disp_sw); end
  endtask

  task automatic test_first_grant();
    rst = 1'b1; step();
    rst = 1'b0; req = 3'b111; step();
    n_checks++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL first_gnt: got %b want 001", gnt); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL first_busy: got %b want 1", busy); end
    step();
    n_checks++; if (disp_dat !== 16'h1111) begin n_fail++; $display("FAIL first_dat: got %h want 1111", disp_dat); end
    n_checks++; if (disp_sw !== 2'd1) begin n_fail++; $display("FAIL first_sw: got %b want 01", disp_sw); end
  endtask

  task automatic test_preempt();
    req = 3'b011;
    for (int k = 0; k < 3; k++) begin
      ce1ms = 1'b1; step(); ce1ms = 1'b0;
      n_checks++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL hold0_tick%0d: got %b want 001", k, gnt); end
    end
    step();
    n_checks++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL preempt_gnt: got %b want 010", gnt); end
    n_checks++; if (disp_dat !== 16'h2222) begin n_fail++; $display("FAIL preempt_dat: got %h want 2222", disp_dat); end
    n_checks++; if (disp_sw !== 2'd2) begin n_fail++; $display("FAIL preempt_sw: got %b want 10", disp_sw); end
    for (int k = 0; k < 3; k++) begin
      ce1ms = 1'b1; step(); ce1ms = 1'b0;
      n_checks++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL hold1_tick%0d: got %b want 010", k, gnt); end
    end
    step();
    n_checks++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL preempt_back: got %b want 001", gnt); end
  endtask

  task automatic test_release();
    req = 3'b010; step();
    n_checks++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL release_handover: got %b want 010", gnt); end
    req = 3'b000; step();
    n_checks++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL release_idle_gnt: got %b want 000", gnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL release_idle_busy: got %b want 0", busy); end
    n_checks++; if (disp_dat !== 16'hDEAD) begin n_fail++; $display("FAIL release_idle_dat: got %h want dead", disp_dat); end
    req = 3'b010; step();
    n_checks++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL regrant1: got %b want 010", gnt); end
    req = 3'b100; step();
    n_checks++; if (gnt !== 3'b100) begin n_fail++; $display("FAIL release_to2_gnt: got %b want 100", gnt); end
    n_checks++; if (disp_dat !== 16'h3333) begin n_fail++; $display("FAIL release_to2_dat: got %h want 3333", disp_dat); end
    n_checks++; if (disp_sw !== 2'd3) begin n_fail++; $display("FAIL release_to2_sw: got %b want 11", disp_sw); end
  endtask

  task automatic test_transient();
    // Owner 2 has hold_cnt 0 here, so passing requests must not steal the grant.
    req = 3'b111; step();
    n_checks++; if (gnt !== 3'b100) begin n_fail++; $display("FAIL transient_a: got %b want 100", gnt); end
    req = 3'b100; step();
    n_checks++; if (gnt !== 3'b100) begin n_fail++; $display("FAIL transient_b: got %b want 100", gnt); end
  endtask

  task automatic test_sole_owner();
    req = 3'b100;
    for (int k = 0; k < 10; k++) begin
      ce1ms = 1'b1; step(); ce1ms = 1'b0; step();
      n_checks++; if (gnt !== 3'b100) begin n_fail++; $display("FAIL sole_tick%0d: got %b want 100", k, gnt); end
    end
    n_checks++; if (disp_dat !== 16'h3333) begin n_fail++; $display("FAIL sole_dat: got %h want 3333", disp_dat); end
  endtask

  task automatic test_reset_own();
    req = 3'b010; step();
    n_checks++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL rstown_setup: got %b want 010", gnt); end
    req = 3'b111; rst = 1'b1; step();
    n_checks++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL rstown_gnt: got %b want 000", gnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstown_busy: got %b want 0", busy); end
    n_checks++; if (disp_dat !== 16'hDEAD) begin n_fail++; $display("FAIL rstown_dat: got %h want dead", disp_dat); end
    rst = 1'b0; step();
    n_checks++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL rstown_regrant: got %b want 001", gnt); end
  endtask

  initial begin
    test_reset();
    test_first_grant();
    test_preempt();
    test_release();
    test_transient();
    test_sole_owner();
    test_reset_own();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/disp_arbiter.md
DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
REQ-001 Parameter HOLD_MS, default 500: minimum ownership time, in ce1ms ticks, before an owner can be preempted; legal range 1..65535.
REQ-002 Parameter IDLE_DAT, default 16'h0000: value driven on disp_dat when no requester owns the display.
REQ-003 clk  input  1: single system clock; all logic on posedge clk.
REQ-004 rst  input  1: reset, synchronous, active-high.
REQ-005 ce1ms  input  1: one-clk-wide 1 ms tick from the display driver.
REQ-006 req  input  3: per-requester display request, bit i = requester i, level-sensitive.
REQ-007 dat0, dat1, dat2  input  16 each: hex value each requester wants shown.
REQ-008 pt0, pt1, pt2  input  2 each: each requester's decimal-point select code, passed to the display SW input.
REQ-009 gnt  output  3: one-hot or zero grant, registered.
REQ-010 disp_dat  output  16: registered data for the display dat input.
REQ-011 disp_sw  output  2: registered point select for the display SW input.
REQ-012 busy  output  1: high while any requester owns the display, registered.

Function
REQ-013 FSM states: IDLE (no owner) and OWN (one owner, index own_idx); busy SHALL be high exactly when state = OWN.
REQ-014 Round-robin pointer last_idx SHALL hold the most recently granted index; search order is last_idx+1, last_idx+2, last_idx+3, modulo 3, choosing the first requester with req set.
REQ-015 In IDLE with req != 0 at a posedge, the block SHALL enter OWN at that same edge: gnt one-hot for the chosen index, last_idx updated, hold_cnt cleared. Latency is one clk from req to gnt.
REQ-016 In IDLE with req == 0, gnt SHALL be 0, disp_dat SHALL be IDLE_DAT, and disp_sw SHALL be 2'b00.
REQ-017 In OWN, each posedge SHALL load disp_dat from dat[own_idx] and disp_sw from pt[own_idx]; disp_dat therefore lags the owner's data by one clk.
REQ-018 hold_cnt is 16 bits wide, SHALL increment on each ce1ms while in OWN, and SHALL saturate at HOLD_MS.
REQ-019 Owner release: if req[own_idx] is low at a posedge, the block SHALL hand over at that edge to the next pending requester in round-robin order, or go to IDLE if none is pending.
REQ-020 Preemption: if req[own_idx] is high, hold_cnt == HOLD_MS and another requester is pending, the block SHALL hand over at that edge to the next pending requester in round-robin order.
REQ-021 If no other requester is pending, the owner SHALL keep the grant indefinitely, regardless of hold_cnt.
REQ-022 A handover from one owner to another SHALL take exactly one edge, with no zero-gnt cycle between owners. hold_cnt SHALL clear, and disp_dat/disp_sw SHALL load the new owner's inputs at the same edge.
REQ-023 A ce1ms tick on the same edge as a grant or handover SHALL NOT count toward the new owner.
REQ-024 Requests that come and go while another requester is the owner SHALL have no effect.
REQ-025 gnt SHALL never have more than one bit set.

Reset
REQ-026 While rst is high at a posedge, the block SHALL load: state = IDLE, gnt = 0, busy = 0, disp_dat = IDLE_DAT, disp_sw = 0, hold_cnt = 0, last_idx = 2 (so requester 0 wins first).
REQ-027 rst SHALL take priority over every other event; reset during OWN drops the grant at that edge.
REQ-028 After rst falls, the first grant SHALL be able to occur on the next posedge.

Verification (bench uses HOLD_MS=3, IDLE_DAT=16'hDEAD)
REQ-029 Reset, then req=3'b000 -> gnt=0, busy=0, disp_dat=16'hDEAD, disp_sw=0.
REQ-030 req=3'b111 from the first edge after reset -> gnt=001 at that edge; disp_dat=dat0 one edge later.
REQ-031 Requester 0 owns, req=3'b011 held -> gnt stays 001 until the edge after the 3rd ce1ms, then gnt=010 with no zero cycle; after 3 more ticks gnt=001.
REQ-032 Requester 1 owns, req drops to 3'b000 -> next edge gnt=0, busy=0, disp_dat=16'hDEAD; with req=3'b100 instead -> next edge gnt=100, disp_dat=dat2, disp_sw=pt2.
REQ-033 Sole requester 2 holds req for 10 ce1ms ticks -> gnt stays 100 throughout (no preemption).
REQ-034 rst pulsed for one clk while gnt=010 and req=3'b111 -> gnt=0 at the reset edge, then gnt=001 at the next edge.
